wb_mem_slave_p: RTL and testbench
=================================

// Module: wb_mem_slave_p
// PURPOSE
//  Parametrised Wishbone classic slave bridging the CPU's Wishbone master to an external SRAM-style memory
//  (cs/we/oe/address/data). It generalises the fixed 8-bit/12-bit memory slave with configurable data and
//  address width, byte selects and programmable wait states. It sits between the bus master and the memory.
// PARAMETERS
//  DW          8     data width in bits; multiple of 8
//  AW          12    word address width
//  WAIT_STATES 2     cycles memory controls are held before sampling/ack; >=1; sync-read memory needs >=2
//  MEM_WORDS   4096  implemented words; used only with WB_SLAVE_ERR_EN
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  reset        in   1       synchronous, active-low reset
//  wb_adr_i     in   AW      word address
//  wb_dat_i     in   DW      write data
//  wb_dat_o     out  DW      read data, valid while wb_ack_o=1
//  wb_sel_i     in   DW/8    byte selects
//  wb_we_i      in   1       1=write, 0=read
//  wb_stb_i     in   1       strobe
//  wb_cyc_i     in   1       bus cycle
//  wb_ack_o     out  1       one-cycle acknowledge
//  wb_err_o     out  1       one-cycle error (constant 0 without WB_SLAVE_ERR_EN)
//  mem_cs       out  1       memory chip select
//  mem_we       out  1       memory write enable
//  mem_oe       out  1       memory output enable
//  mem_be       out  DW/8    memory byte enables
//  mem_dir      out  AW      memory address
//  mem_indata   out  DW      data to memory
//  mem_outdata  in   DW      data from memory
// BEHAVIOUR
//  - All outputs registered. reset=0 at an edge: state IDLE, counter 0, every output 0; aborts any access.
//  - FSM IDLE -> ACCESS -> ACK -> IDLE. Request = wb_cyc_i & wb_stb_i sampled in IDLE.
//  - IDLE: on request, latch adr/dat/sel/we; enter ACCESS with counter=WAIT_STATES-1.
//  - ACCESS: mem_cs=1, mem_dir/mem_indata/mem_be from latched values, mem_oe=~we; counter decrements.
//    mem_we=1 only in the last ACCESS cycle (counter==0) and only if we=1 and sel!=0.
//  - Last ACCESS cycle: on read, wb_dat_o <= mem_outdata at the edge entering ACK.
//  - ACK: wb_ack_o=1 for exactly one cycle, mem_* all 0; always returns to IDLE.
//  - Latency: request sampled at edge k -> ACCESS cycles k+1..k+W -> ack during cycle k+W+1.
//  - Back-to-back: a new request is only sampled in IDLE, so one idle cycle separates consecutive accesses.
//  - Write with sel=0: full timing, ack given, no mem_we pulse.
//  - Abort: wb_cyc_i=0 during ACCESS -> next state IDLE, no ack, mem_* 0; a write aborted before
//    its last ACCESS cycle never asserts mem_we.
//  - wb_stb_i dropped while wb_cyc_i stays 1 is not an abort (classic: master holds stb until ack).
//  - wb_dat_o keeps its last value outside ACK; checkers sample it only with wb_ack_o=1.
//  - Without the error option, the address is used modulo 2^AW (wrap-around), no range check.
// CONFIGURATION
//  WB_SLAVE_ERR_EN defined: in IDLE, a request with wb_adr_i >= MEM_WORDS goes IDLE -> ERR -> IDLE;
//    wb_err_o=1 for one cycle (the cycle after sampling), no ack, mem_cs never asserted.
//  WB_SLAVE_ERR_EN undefined: no ERR state; wb_err_o tied 0; MEM_WORDS ignored.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles mid-write -> all outputs 0, mem_we never 1, FSM IDLE.
//  2 Write DW=8,W=2: adr=0x005 dat=0xA5 sel=1 -> mem_we 1 cycle in ACCESS#2, ack at k+3, then read
//    adr=0x005 -> wb_dat_o=0xA5 with ack at k+3.
//  3 DW=16 sel=2'b10 write 0xBEEF over 0x1234 -> mem_be=10; readback 0xBE34; sel=00 write: ack, no mem_we.
//  4 Abort: drop wb_cyc_i in ACCESS#1 of write -> no ack, no mem_we, memory unchanged, next request served.
//  5 WAIT_STATES=1 and 4 with comb-read model -> ack at k+2 and k+5; back-to-back shows 1 idle cycle.
//  6 WB_SLAVE_ERR_EN, MEM_WORDS=1024: adr=0x400 -> wb_err_o at k+1, no ack, mem_cs 0; adr=0x3FF normal.

Source files
------------

// File: rtl/wb_mem_slave_p.sv
// Wishbone classic slave to SRAM-style memory, with byte selects and wait states.
// Optional WB_SLAVE_ERR_EN: out-of-range word addresses get wb_err_o instead of an access.
module wb_mem_slave_p #(
  parameter int DW          = 8,
  parameter int AW          = 12,
  parameter int WAIT_STATES = 2,
  parameter int MEM_WORDS   = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            mem_cs,
  output logic            mem_we,
  output logic            mem_oe,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_dir,
  output logic [DW-1:0]   mem_indata,
  input  logic [DW-1:0]   mem_outdata
);

  localparam int SW = DW / 8;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK,
    S_ERR
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [DW-1:0]   r_dato;
  logic            r_ack;
  logic            r_cs;
  logic            r_mwe;
  logic            r_oe;
  logic [SW-1:0]   r_be;
  logic [AW-1:0]   r_dir;
  logic [DW-1:0]   r_ind;
  logic            w_req;

  assign w_req = wb_cyc_i & wb_stb_i;

`ifdef WB_SLAVE_ERR_EN
  localparam logic [AW:0] LIM = (AW+1)'(MEM_WORDS);
  logic r_err;
  assign wb_err_o = r_err;
`else
  assign wb_err_o = 1'b0;
`endif

  // The memory-side registers double as the latched request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_dato  <= '0;
      r_ack   <= 1'b0;
      r_cs    <= 1'b0;
      r_mwe   <= 1'b0;
      r_oe    <= 1'b0;
      r_be    <= '0;
      r_dir   <= '0;
      r_ind   <= '0;
`ifdef WB_SLAVE_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef WB_SLAVE_ERR_EN
      r_err <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
`ifdef WB_SLAVE_ERR_EN
            if ({1'b0, wb_adr_i} >= LIM) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else
`endif
            begin
              r_state <= S_ACCESS;
              r_cnt   <= CW'(WAIT_STATES - 1);
              r_cs    <= 1'b1;
              r_dir   <= wb_adr_i;
              r_ind   <= wb_dat_i;
              r_be    <= wb_sel_i;
              r_we    <= wb_we_i;
              r_oe    <= ~wb_we_i;
              r_mwe   <= (WAIT_STATES == 1) && wb_we_i && (|wb_sel_i);
            end
          end
        end
        S_ACCESS: begin
          if (!wb_cyc_i || r_cnt == '0) begin
            if (wb_cyc_i) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
              if (!r_we) r_dato <= mem_outdata;
            end else begin
              r_state <= S_IDLE;
            end
            r_cs  <= 1'b0;
            r_mwe <= 1'b0;
            r_oe  <= 1'b0;
            r_be  <= '0;
            r_dir <= '0;
            r_ind <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            r_mwe <= (r_cnt == CW'(1)) && r_we && (|r_be);
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb_dat_o   = r_dato;
  assign wb_ack_o   = r_ack;
  assign mem_cs     = r_cs;
  assign mem_we     = r_mwe;
  assign mem_oe     = r_oe;
  assign mem_be     = r_be;
  assign mem_dir    = r_dir;
  assign mem_indata = r_ind;

endmodule

// File: tb/tb_wb_mem_slave_p.sv
// Directed bench for wb_mem_slave_p: four instances (8-bit W=2, 16-bit W=2/1/4)
// each backed by a combinational-read byte-enabled memory model.
module tb_wb_mem_slave_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [11:0] t_adr;
  logic [15:0] t_dat;
  logic [1:0]  t_sel;
  logic        t_we;
  logic        cyc [4];
  logic        stb [4];

  // unit 3: DW=8
  logic [7:0]  a_dato, a_ind, a_outd;
  logic        a_ack, a_err, a_cs, a_mwe, a_oe;
  logic [0:0]  a_be;
  logic [11:0] a_dir;
  logic [7:0]  memA [4096];

  // units 0..2: DW=16
  logic [15:0] b_dato [3];
  logic [15:0] b_ind  [3];
  logic [15:0] b_outd [3];
  logic        b_ack  [3];
  logic        b_err  [3];
  logic        b_cs   [3];
  logic        b_mwe  [3];
  logic        b_oe   [3];
  logic [1:0]  b_be   [3];
  logic [11:0] b_dir  [3];
  logic [15:0] memB [3][4096];

  wb_mem_slave_p #(.DW(8), .AW(12), .WAIT_STATES(2)) u_a (
    .clk(clk), .reset(reset), .wb_adr_i(t_adr), .wb_dat_i(t_dat[7:0]),
    .wb_dat_o(a_dato), .wb_sel_i(t_sel[0:0]), .wb_we_i(t_we),
    .wb_stb_i(stb[3]), .wb_cyc_i(cyc[3]), .wb_ack_o(a_ack), .wb_err_o(a_err),
    .mem_cs(a_cs), .mem_we(a_mwe), .mem_oe(a_oe), .mem_be(a_be),
    .mem_dir(a_dir), .mem_indata(a_ind), .mem_outdata(a_outd));

  wb_mem_slave_p #(.DW(16), .AW(12), .WAIT_STATES(2), .MEM_WORDS(1024)) u_b0 (
    .clk(clk), .reset(reset), .wb_adr_i(t_adr), .wb_dat_i(t_dat),
    .wb_dat_o(b_dato[0]), .wb_sel_i(t_sel), .wb_we_i(t_we),
    .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]), .wb_ack_o(b_ack[0]), .wb_err_o(b_err[0]),
    .mem_cs(b_cs[0]), .mem_we(b_mwe[0]), .mem_oe(b_oe[0]), .mem_be(b_be[0]),
    .mem_dir(b_dir[0]), .mem_indata(b_ind[0]), .mem_outdata(b_outd[0]));

  wb_mem_slave_p #(.DW(16), .AW(12), .WAIT_STATES(1)) u_b1 (
    .clk(clk), .reset(reset), .wb_adr_i(t_adr), .wb_dat_i(t_dat),
    .wb_dat_o(b_dato[1]), .wb_sel_i(t_sel), .wb_we_i(t_we),
    .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]), .wb_ack_o(b_ack[1]), .wb_err_o(b_err[1]),
    .mem_cs(b_cs[1]), .mem_we(b_mwe[1]), .mem_oe(b_oe[1]), .mem_be(b_be[1]),
    .mem_dir(b_dir[1]), .mem_indata(b_ind[1]), .mem_outdata(b_outd[1]));

  wb_mem_slave_p #(.DW(16), .AW(12), .WAIT_STATES(4)) u_b2 (
    .clk(clk), .reset(reset), .wb_adr_i(t_adr), .wb_dat_i(t_dat),
    .wb_dat_o(b_dato[2]), .wb_sel_i(t_sel), .wb_we_i(t_we),
    .wb_stb_i(stb[2]), .wb_cyc_i(cyc[2]), .wb_ack_o(b_ack[2]), .wb_err_o(b_err[2]),
    .mem_cs(b_cs[2]), .mem_we(b_mwe[2]), .mem_oe(b_oe[2]), .mem_be(b_be[2]),
    .mem_dir(b_dir[2]), .mem_indata(b_ind[2]), .mem_outdata(b_outd[2]));

  assign a_outd = memA[a_dir];
  assign b_outd[0] = memB[0][b_dir[0]];
  assign b_outd[1] = memB[1][b_dir[1]];
  assign b_outd[2] = memB[2][b_dir[2]];

  always @(posedge clk) begin
    if (a_cs && a_mwe && a_be[0]) memA[a_dir] <= a_ind;
    for (int i = 0; i < 3; i++) begin
      if (b_cs[i] && b_mwe[i]) begin
        if (b_be[i][0]) memB[i][b_dir[i]][7:0]  <= b_ind[i][7:0];
        if (b_be[i][1]) memB[i][b_dir[i]][15:8] <= b_ind[i][15:8];
      end
    end
  end

  int err_seen = 0;
  always @(posedge clk)
    if (a_err | b_err[0] | b_err[1] | b_err[2]) err_seen++;

  // view of the selected unit
  int          cur = 3;
  logic        m_ack, m_cs, m_mwe, m_oe, m_err;
  logic [15:0] m_dato;
  logic [1:0]  m_be;
  logic [11:0] m_dir;

  always_comb begin
    m_ack = 1'b0; m_cs = 1'b0; m_mwe = 1'b0; m_oe = 1'b0; m_err = 1'b0;
    m_dato = '0; m_be = '0; m_dir = '0;
    if (cur == 3) begin
      m_ack = a_ack; m_cs = a_cs; m_mwe = a_mwe; m_oe = a_oe; m_err = a_err;
      m_dato = {8'h00, a_dato}; m_be = {1'b0, a_be}; m_dir = a_dir;
    end else if (cur >= 0 && cur < 3) begin
      m_ack = b_ack[cur]; m_cs = b_cs[cur]; m_mwe = b_mwe[cur];
      m_oe = b_oe[cur]; m_err = b_err[cur];
      m_dato = b_dato[cur]; m_be = b_be[cur]; m_dir = b_dir[cur];
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  int          x_lat, x_wecnt, x_wepos;
  logic [15:0] x_rd;
  logic [1:0]  x_be0;
  logic        x_oe0;

  // Full transaction; caller must leave the unit idle. Returns with unit idle again.
  task automatic xfer(input int u, input logic we, input logic [11:0] adr,
                      input logic [15:0] dat, input logic [1:0] sel);
    bit done;
    cur = u; t_we = we; t_adr = adr; t_dat = dat; t_sel = sel;
    cyc[u] = 1'b1; stb[u] = 1'b1;
    x_lat = -1; x_wecnt = 0; x_wepos = -1; x_rd = '0; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin x_be0 = m_be; x_oe0 = m_oe; end
      if (m_mwe) begin x_wecnt++; x_wepos = n; end
      if (m_ack) begin x_lat = n; x_rd = m_dato; done = 1'b1; end
    end
    cyc[u] = 1'b0; stb[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tot++;
    if ({a_ack, a_err, a_cs, a_mwe, a_oe, a_be, a_dir, a_ind, a_dato} !== '0)
      $display("FAIL reset_a outputs got %h want 0",
               {a_ack, a_err, a_cs, a_mwe, a_oe, a_be, a_dir, a_ind, a_dato});
    else n_pass++;
    n_tot++;
    if ({b_ack[0], b_cs[0], b_mwe[0], b_oe[0], b_be[0], b_dir[0], b_ind[0], b_dato[0]} !== '0)
      $display("FAIL reset_b outputs nonzero got %h",
               {b_ack[0], b_cs[0], b_mwe[0], b_oe[0], b_be[0], b_dir[0], b_ind[0], b_dato[0]});
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    xfer(3, 1'b1, 12'h010, 16'h0033, 2'b01);
    n_tot++;
    if (x_lat !== 2) $display("FAIL reset_prewrite lat got %0d want 2", x_lat);
    else n_pass++;
    // write interrupted by reset during ACCESS#1
    cur = 3; t_we = 1'b1; t_adr = 12'h010; t_dat = 16'h005A; t_sel = 2'b01;
    cyc[3] = 1'b1; stb[3] = 1'b1;
    @(posedge clk); #1;
    n_tot++;
    if (a_cs !== 1'b1) $display("FAIL reset_midwrite_cs got %b want 1", a_cs);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_tot++;
      if ({a_ack, a_cs, a_mwe, a_oe, a_be, a_dir, a_ind} !== '0)
        $display("FAIL reset_hold%0d outputs got %h want 0", i,
                 {a_ack, a_cs, a_mwe, a_oe, a_be, a_dir, a_ind});
      else n_pass++;
    end
    cyc[3] = 1'b0; stb[3] = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    n_tot++;
    if ({a_ack, a_cs, a_mwe} !== 3'b000)
      $display("FAIL reset_release got %b want 000", {a_ack, a_cs, a_mwe});
    else n_pass++;
    n_tot++;
    if (memA[12'h010] !== 8'h33)
      $display("FAIL reset_mem got %h want 33", memA[12'h010]);
    else n_pass++;
  endtask

  task automatic test_write_read();
    xfer(3, 1'b1, 12'h005, 16'h00A5, 2'b01);
    n_tot++;
    if (x_lat !== 2) $display("FAIL wr8_lat got %0d want 2", x_lat);
    else n_pass++;
    n_tot++;
    if (x_wecnt !== 1 || x_wepos !== 1)
      $display("FAIL wr8_mem_we cnt/pos got %0d/%0d want 1/1", x_wecnt, x_wepos);
    else n_pass++;
    n_tot++;
    if (memA[12'h005] !== 8'hA5) $display("FAIL wr8_mem got %h want a5", memA[12'h005]);
    else n_pass++;
    xfer(3, 1'b0, 12'h005, 16'h0000, 2'b01);
    n_tot++;
    if (x_lat !== 2 || x_rd[7:0] !== 8'hA5)
      $display("FAIL rd8 lat/data got %0d/%h want 2/a5", x_lat, x_rd[7:0]);
    else n_pass++;
    n_tot++;
    if (x_oe0 !== 1'b1 || x_wecnt !== 0)
      $display("FAIL rd8_oe_we got %b/%0d want 1/0", x_oe0, x_wecnt);
    else n_pass++;
  endtask

  task automatic test_byte_sel();
    xfer(0, 1'b1, 12'h020, 16'h1234, 2'b11);
    xfer(0, 1'b1, 12'h020, 16'hBEEF, 2'b10);
    n_tot++;
    if (x_be0 !== 2'b10) $display("FAIL sel_be got %b want 10", x_be0);
    else n_pass++;
    xfer(0, 1'b0, 12'h020, 16'h0000, 2'b11);
    n_tot++;
    if (x_rd !== 16'hBE34) $display("FAIL sel_read got %h want be34", x_rd);
    else n_pass++;
    xfer(0, 1'b1, 12'h020, 16'hFFFF, 2'b00);
    n_tot++;
    if (x_lat !== 2 || x_wecnt !== 0)
      $display("FAIL sel0_write lat/we got %0d/%0d want 2/0", x_lat, x_wecnt);
    else n_pass++;
    n_tot++;
    if (memB[0][12'h020] !== 16'hBE34)
      $display("FAIL sel0_mem got %h want be34", memB[0][12'h020]);
    else n_pass++;
  endtask

  task automatic test_abort();
    int acks, wes, css;
    bit done;
    xfer(3, 1'b1, 12'h030, 16'h0011, 2'b01);
    cur = 3; t_we = 1'b1; t_adr = 12'h030; t_dat = 16'h0077; t_sel = 2'b01;
    cyc[3] = 1'b1; stb[3] = 1'b1;
    @(posedge clk); #1;
    cyc[3] = 1'b0;
    acks = 0; wes = 0; css = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_ack) acks++;
      if (a_mwe) wes++;
      if (a_cs) css++;
    end
    stb[3] = 1'b0;
    n_tot++;
    if (acks !== 0 || wes !== 0 || css !== 0)
      $display("FAIL abort ack/we/cs got %0d/%0d/%0d want 0/0/0", acks, wes, css);
    else n_pass++;
    n_tot++;
    if (memA[12'h030] !== 8'h11) $display("FAIL abort_mem got %h want 11", memA[12'h030]);
    else n_pass++;
    xfer(3, 1'b0, 12'h030, 16'h0000, 2'b01);
    n_tot++;
    if (x_lat !== 2 || x_rd[7:0] !== 8'h11)
      $display("FAIL abort_next lat/data got %0d/%h want 2/11", x_lat, x_rd[7:0]);
    else n_pass++;
    // stb dropped with cyc held is not an abort
    t_we = 1'b1; t_adr = 12'h031; t_dat = 16'h0022; t_sel = 2'b01;
    cyc[3] = 1'b1; stb[3] = 1'b1;
    @(posedge clk); #1;
    stb[3] = 1'b0;
    x_lat = -1; done = 1'b0;
    for (int n = 1; n < 10 && !done; n++) begin
      @(posedge clk); #1;
      if (a_ack) begin x_lat = n; done = 1'b1; end
    end
    cyc[3] = 1'b0;
    @(posedge clk); #1;
    n_tot++;
    if (x_lat !== 2) $display("FAIL stb_drop lat got %0d want 2", x_lat);
    else n_pass++;
    n_tot++;
    if (memA[12'h031] !== 8'h22) $display("FAIL stb_drop_mem got %h want 22", memA[12'h031]);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    xfer(1, 1'b1, 12'h040, 16'hCAFE, 2'b11);
    n_tot++;
    if (x_lat !== 1 || x_wecnt !== 1 || x_wepos !== 0)
      $display("FAIL w1_write lat/cnt/pos got %0d/%0d/%0d want 1/1/0",
               x_lat, x_wecnt, x_wepos);
    else n_pass++;
    xfer(1, 1'b0, 12'h040, 16'h0000, 2'b11);
    n_tot++;
    if (x_lat !== 1 || x_rd !== 16'hCAFE)
      $display("FAIL w1_read lat/data got %0d/%h want 1/cafe", x_lat, x_rd);
    else n_pass++;
    xfer(2, 1'b1, 12'h041, 16'h1357, 2'b11);
    n_tot++;
    if (x_lat !== 4 || x_wecnt !== 1 || x_wepos !== 3)
      $display("FAIL w4_write lat/cnt/pos got %0d/%0d/%0d want 4/1/3",
               x_lat, x_wecnt, x_wepos);
    else n_pass++;
    xfer(2, 1'b0, 12'h041, 16'h0000, 2'b11);
    n_tot++;
    if (x_lat !== 4 || x_rd !== 16'h1357)
      $display("FAIL w4_read lat/data got %0d/%h want 4/1357", x_lat, x_rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit done;
    xfer(0, 1'b1, 12'h040, 16'h9ABC, 2'b11);
    cur = 0; t_we = 1'b0; t_adr = 12'h020; t_sel = 2'b11;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(posedge clk); #1;
      if (m_ack) done = 1'b1;
    end
    n_tot++;
    if (!done || m_dato !== 16'hBE34)
      $display("FAIL b2b_first ack/data got %b/%h want 1/be34", done, m_dato);
    else n_pass++;
    t_adr = 12'h040;
    @(posedge clk); #1;
    n_tot++;
    if (m_cs !== 1'b0 || m_ack !== 1'b0)
      $display("FAIL b2b_idle cs/ack got %b/%b want 0/0", m_cs, m_ack);
    else n_pass++;
    @(posedge clk); #1;
    n_tot++;
    if (m_cs !== 1'b1 || m_dir !== 12'h040)
      $display("FAIL b2b_second cs/dir got %b/%h want 1/040", m_cs, m_dir);
    else n_pass++;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(posedge clk); #1;
      if (m_ack) done = 1'b1;
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    n_tot++;
    if (!done || m_dato !== 16'h9ABC)
      $display("FAIL b2b_second_data ack/data got %b/%h want 1/9abc", done, m_dato);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_err();
`ifdef WB_SLAVE_ERR_EN
    int bad;
    cur = 0; t_we = 1'b0; t_adr = 12'h400; t_sel = 2'b11;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk); #1;
    n_tot++;
    if (m_err !== 1'b1 || m_ack !== 1'b0 || m_cs !== 1'b0)
      $display("FAIL err_pulse err/ack/cs got %b/%b/%b want 1/0/0", m_err, m_ack, m_cs);
    else n_pass++;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (m_err || m_ack || m_cs) bad++;
    end
    n_tot++;
    if (bad !== 0) $display("FAIL err_after got %0d bad cycles want 0", bad);
    else n_pass++;
    xfer(0, 1'b1, 12'h3FF, 16'h4321, 2'b11);
    n_tot++;
    if (x_lat !== 2 || memB[0][12'h3FF] !== 16'h4321)
      $display("FAIL err_inrange lat/mem got %0d/%h want 2/4321", x_lat, memB[0][12'h3FF]);
    else n_pass++;
`else
    xfer(0, 1'b1, 12'h400, 16'h4321, 2'b11);
    n_tot++;
    if (x_lat !== 2 || memB[0][12'h400] !== 16'h4321)
      $display("FAIL noerr_high lat/mem got %0d/%h want 2/4321", x_lat, memB[0][12'h400]);
    else n_pass++;
    n_tot++;
    if (err_seen !== 0) $display("FAIL noerr_err_o got %0d pulses want 0", err_seen);
    else n_pass++;
`endif
  endtask

  initial begin
    t_adr = '0; t_dat = '0; t_sel = '0; t_we = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_byte_sel();
    test_abort();
    test_wait_states();
    test_back_to_back();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
